weight_read_sequencer: RTL and testbench
========================================

Name: weight_read_sequencer

Overview:
- Controls one neuron's weight memory (1-cycle registered-read BRAM, `numWeight` words) during a single evaluation pass.
- Accepts the streamed input activations and issues one weight read per accepted input.
- Realigns each input with its returned weight and presents aligned (x, w) pairs to the neuron MAC.
- Flags the first and last pair, signals completion, and detects inputs arriving outside a pass.

Parameters:
- numWeight, 784, weights per neuron and inputs per pass (1..2**addressWidth).
- addressWidth, 10, weight memory depth is 2**addressWidth words.
- dataWidth, 16, width of activations and weights.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a new pass.
- in_valid  in  1  input activation valid.
- in_data  in  dataWidth  input activation.
- w_ren  out  1  weight memory read enable.
- w_raddr  out  addressWidth+1  weight memory read address.
- w_rdata  in  dataWidth  weight memory read data, valid 1 cycle after w_ren.
- mac_valid  out  1  aligned pair valid.
- mac_x  out  dataWidth  aligned activation.
- mac_w  out  dataWidth  aligned weight.
- mac_first  out  1  qualifies the pair at index 0.
- mac_last  out  1  qualifies the pair at index numWeight-1.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  one-cycle pulse when a pass completes.
- err_overrun  out  1  sticky flag: in_valid seen while not in RUN.

Behaviour:
- Clock and reset: single clock `clk`. `rst_n` is asynchronous and active-low.
- Reset state: IDLE, addr counter = 0, all outputs 0 (mac_x and mac_w registers also 0).
- States:
  - IDLE: start -> RUN (counter = 0, err_overrun cleared).
  - RUN: each cycle with in_valid=1 is an accept. On an accept with counter == numWeight-1 -> DRAIN.
  - DRAIN: 1 cycle, unconditional -> DONE.
  - DONE: done=1 for 1 cycle, unconditional -> IDLE.
- Read issue:
  - w_ren = in_valid & (state==RUN), combinational.
  - w_raddr = counter register, zero-extended to addressWidth+1 bits.
  - Counter increments on each accept and returns to 0 when the pass completes.
  - No read is issued outside RUN.
- Alignment: total latency from accept to mac_valid is exactly 1 cycle.
  - mac_valid <= accept (registered).
  - mac_x <= in_data (registered).
  - mac_first <= accept & counter==0.
  - mac_last <= accept & counter==numWeight-1.
  - mac_w = w_rdata, pass-through, so it is aligned by the BRAM's own read latency.
- Stalls: in_valid may drop for any number of cycles in RUN. The counter holds, no read is issued, and mac_valid=0 on the following cycle. There are no gaps required and no throughput limit; an accept every cycle is legal.
- Last-pair timing: the last pair appears on mac_* in the DRAIN cycle. done is asserted the next cycle, exactly 2 cycles after the last accept.
- busy = (state==RUN) | (state==DRAIN).
- err_overrun:
  - Set when in_valid=1 in IDLE, DRAIN or DONE.
  - Such an input is dropped: no read issued, no mac_valid.
  - Remains set until the next start or reset.
- start in RUN (restart):
  - Counter -> 0 and the state stays RUN.
  - An accept in the same cycle as start is dropped.
  - mac_valid is forced 0 on the cycle after start, so the in-flight pair is discarded.
  - err_overrun is cleared.
- start in DRAIN or DONE: ignored (err_overrun not cleared). The pass completes normally.
- start together with in_valid in IDLE: start takes effect, the input is dropped and err_overrun stays 0. The first accept occurs on the next cycle.
- Reset mid-pass: immediate return to the reset state, with mac_valid and done forced 0 asynchronously.
- numWeight=1: the first accept produces mac_first and mac_last on the same pair and enters DRAIN.

Test Plan:
- Reset, start, then 784 consecutive in_valid with in_data=k -> w_raddr goes 0..783. mac_valid runs 784 cycles with mac_x=k paired with mem[k]. mac_first on pair 0, mac_last on pair 783. done 2 cycles after the last accept; busy drops with done.
- Same pass with in_valid toggling 1,0,0,1 -> counter holds across gaps, 784 reads total, each mac_valid exactly 1 cycle after its accept, no duplicated addresses.
- in_valid=1 for 3 cycles in IDLE -> w_ren stays 0, err_overrun=1. A subsequent start clears it to 0.
- start at pass index 100, then 784 accepts -> the pair for index 100 is suppressed, addresses restart at 0, exactly 784 further pairs, done once.
- rst_n low at index 400 -> all outputs 0 immediately, state IDLE. start after release -> w_raddr begins at 0.
- numWeight=1 build: start plus one accept -> one pair with mac_first=mac_last=1, done 2 cycles later.

Source files
------------

// File: rtl/weight_read_sequencer.sv
// Sequences one neuron's weight reads for a pass and realigns each input with its weight; pairs reach the MAC 1 cycle after accept.
// No backpressure: every in_valid in RUN is accepted, and inputs outside RUN are dropped and flagged.
module weight_read_sequencer #(
  parameter int numWeight    = 784,
  parameter int addressWidth = 10,
  parameter int dataWidth    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    in_valid,
  input  logic [dataWidth-1:0]    in_data,
  output logic                    w_ren,
  output logic [addressWidth:0]   w_raddr,
  input  logic [dataWidth-1:0]    w_rdata,
  output logic                    mac_valid,
  output logic [dataWidth-1:0]    mac_x,
  output logic [dataWidth-1:0]    mac_w,
  output logic                    mac_first,
  output logic                    mac_last,
  output logic                    busy,
  output logic                    done,
  output logic                    err_overrun
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [addressWidth-1:0] LAST_IDX = addressWidth'(numWeight - 1);

  state_t                  state;
  logic [addressWidth-1:0] cnt;
  logic                    in_run;
  logic                    accept;
  logic                    at_last;

  assign in_run  = (state == RUN);
  // A start in RUN restarts the pass, so an input arriving with it is discarded.
  assign accept  = in_valid & in_run & ~start;
  assign at_last = (cnt == LAST_IDX);

  assign w_ren   = in_valid & in_run;
  assign w_raddr = {1'b0, cnt};
  // The BRAM's own 1-cycle read latency lines the weight up with the registered activation.
  assign mac_w   = w_rdata;
  assign busy    = in_run | (state == DRAIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      mac_valid   <= 1'b0;
      mac_x       <= '0;
      mac_first   <= 1'b0;
      mac_last    <= 1'b0;
      done        <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      mac_valid <= accept;
      mac_x     <= in_data;
      mac_first <= accept & (cnt == '0);
      mac_last  <= accept & at_last;
      done      <= (state == DRAIN);
      case (state)
        IDLE: begin
          if (start) begin
            state       <= RUN;
            cnt         <= '0;
            err_overrun <= 1'b0;
          end else if (in_valid) begin
            err_overrun <= 1'b1;
          end
        end
        RUN: begin
          if (start) begin
            cnt         <= '0;
            err_overrun <= 1'b0;
          end else if (in_valid) begin
            if (at_last) begin
              cnt   <= '0;
              state <= DRAIN;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (in_valid) err_overrun <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          if (in_valid) err_overrun <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_read_sequencer.sv
// Directed bench for weight_read_sequencer with a behavioural BRAM and a timestamped pair scoreboard.
module tb_weight_read_sequencer;

  localparam int N  = 784;
  localparam int AW = 10;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, in_valid;
  logic [DW-1:0] in_data;
  logic          w_ren;
  logic [AW:0]   w_raddr;
  logic [DW-1:0] w_rdata;
  logic          mac_valid, mac_first, mac_last, busy, done, err_overrun;
  logic [DW-1:0] mac_x, mac_w;

  logic          start1, iv1;
  logic [DW-1:0] d1;
  logic          w_ren1;
  logic [AW:0]   w_raddr1;
  logic [DW-1:0] w_rdata1;
  logic          mac_valid1, mac_first1, mac_last1, busy1, done1, err1;
  logic [DW-1:0] mac_x1, mac_w1;

  always #5 clk = ~clk;

  weight_read_sequencer #(.numWeight(N), .addressWidth(AW), .dataWidth(DW)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .w_ren(w_ren), .w_raddr(w_raddr), .w_rdata(w_rdata),
    .mac_valid(mac_valid), .mac_x(mac_x), .mac_w(mac_w), .mac_first(mac_first),
    .mac_last(mac_last), .busy(busy), .done(done), .err_overrun(err_overrun));

  weight_read_sequencer #(.numWeight(1), .addressWidth(AW), .dataWidth(DW)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .in_valid(iv1), .in_data(d1),
    .w_ren(w_ren1), .w_raddr(w_raddr1), .w_rdata(w_rdata1),
    .mac_valid(mac_valid1), .mac_x(mac_x1), .mac_w(mac_w1), .mac_first(mac_first1),
    .mac_last(mac_last1), .busy(busy1), .done(done1), .err_overrun(err1));

  function automatic logic [DW-1:0] wfn(input int unsigned a);
    return DW'(a * 37) ^ 16'hC3A5;
  endfunction

  // Registered-read weight memories
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_rdata  <= '0;
      w_rdata1 <= '0;
    end else begin
      if (w_ren)  w_rdata  <= wfn(int'(w_raddr));
      if (w_ren1) w_rdata1 <= wfn(int'(w_raddr1));
    end
  end

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [DW-1:0] x;
    logic [DW-1:0] w;
    logic          first;
    logic          last;
    int            cyc;
  } pair_t;

  pair_t sb[$];
  pair_t mon_e;
  logic  mon_exp;

  // A pair pushed in cycle c must appear on mac_* in cycle c+1 and nowhere else.
  always @(negedge clk) begin
    if (rst_n) begin
      mon_exp = (sb.size() > 0) && (sb[0].cyc == cyc_n - 1);
      chk("mac_valid", 32'(mac_valid), 32'(mon_exp));
      if (mon_exp) begin
        mon_e = sb.pop_front();
        if (mac_valid) begin
          chk("mac_x", 32'(mac_x), 32'(mon_e.x));
          chk("mac_w", 32'(mac_w), 32'(mon_e.w));
          chk("mac_first", 32'(mac_first), 32'(mon_e.first));
          chk("mac_last", 32'(mac_last), 32'(mon_e.last));
        end
      end
    end
  end

  // Reference state: 0 IDLE, 1 RUN, 2 DRAIN, 3 DONE
  int   ms = 0;
  int   mcnt = 0;
  logic merr = 1'b0;

  task automatic cyc(input logic st, input logic iv, input logic [DW-1:0] d);
    logic acc;
    start = st; in_valid = iv; in_data = d;
    @(negedge clk);
    acc = iv && ms == 1 && !st;
    chk("w_ren", 32'(w_ren), 32'(iv && ms == 1));
    if (iv && ms == 1) chk("w_raddr", 32'(w_raddr), 32'(mcnt));
    chk("busy", 32'(busy), 32'(ms == 1 || ms == 2));
    chk("done", 32'(done), 32'(ms == 3));
    chk("err_overrun", 32'(err_overrun), 32'(merr));
    if (acc) sb.push_back('{d, wfn(mcnt), mcnt == 0, mcnt == N - 1, cyc_n});
    @(posedge clk);
    case (ms)
      0: if (st) begin ms = 1; mcnt = 0; merr = 1'b0; end else if (iv) merr = 1'b1;
      1: if (st) begin mcnt = 0; merr = 1'b0; end
         else if (iv) begin
           if (mcnt == N - 1) begin ms = 2; mcnt = 0; end else mcnt++;
         end
      2: begin if (iv) merr = 1'b1; ms = 3; end
      3: begin if (iv) merr = 1'b1; ms = 0; end
      default: ms = 0;
    endcase
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_mac_valid"}, 32'(mac_valid), 0);
    chk({tag, "_mac_x"}, 32'(mac_x), 0);
    chk({tag, "_mac_w"}, 32'(mac_w), 0);
    chk({tag, "_mac_first"}, 32'(mac_first), 0);
    chk({tag, "_mac_last"}, 32'(mac_last), 0);
    chk({tag, "_w_ren"}, 32'(w_ren), 0);
    chk({tag, "_w_raddr"}, 32'(w_raddr), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err_overrun), 0);
  endtask

  initial begin
    int acc_n;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    start1 = 1'b0; iv1 = 1'b0; d1 = '0;
    #3;
    chk_zero("reset");
    chk("reset_mac_valid1", 32'(mac_valid1), 0);
    chk("reset_done1", 32'(done1), 0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    // Inputs while idle are dropped and flagged; start clears the flag.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 16'h0BAD);

    // Full pass with back-to-back accepts
    cyc(1'b1, 1'b0, '0);
    for (int k = 0; k < N; k++) cyc(1'b0, 1'b1, DW'(k));
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, '0);

    // Start with in_valid in IDLE, then gappy input pattern
    cyc(1'b1, 1'b1, 16'hDEAD);
    acc_n = 0;
    for (int i = 0; acc_n < N; i++) begin
      logic v;
      v = (i % 4 == 0) || (i % 4 == 3);
      cyc(1'b0, v, DW'(acc_n) ^ 16'h8000);
      if (v) acc_n++;
    end
    cyc(1'b0, 1'b1, 16'h0001);   // DRAIN: overrun
    cyc(1'b1, 1'b0, '0);         // DONE: start ignored
    cyc(1'b0, 1'b0, '0);

    // Restart at index 100
    cyc(1'b1, 1'b0, '0);
    for (int k = 0; k < 100; k++) cyc(1'b0, 1'b1, DW'(k));
    cyc(1'b1, 1'b1, 16'd100);
    for (int k = 0; k < N; k++) cyc(1'b0, 1'b1, DW'(k + 1000));
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, '0);

    // Reset mid-pass at index 400
    cyc(1'b1, 1'b0, '0);
    for (int k = 0; k < 400; k++) cyc(1'b0, 1'b1, DW'(k + 3000));
    in_valid = 1'b1;
    rst_n = 1'b0;
    #2;
    chk_zero("midreset");
    sb.delete();
    ms = 0; mcnt = 0; merr = 1'b0;
    in_valid = 1'b0;
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    cyc(1'b1, 1'b0, '0);
    for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, DW'(k + 5000));
    cyc(1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, '0);
    chk("sb_empty", 32'(sb.size()), 0);

    // Single-weight instance
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; iv1 = 1'b1; d1 = 16'h1234;
    @(negedge clk);
    chk("n1_w_ren", 32'(w_ren1), 1);
    chk("n1_w_raddr", 32'(w_raddr1), 0);
    @(posedge clk); #1;
    iv1 = 1'b0;
    @(negedge clk);
    chk("n1_mac_valid", 32'(mac_valid1), 1);
    chk("n1_mac_first", 32'(mac_first1), 1);
    chk("n1_mac_last", 32'(mac_last1), 1);
    chk("n1_mac_x", 32'(mac_x1), 32'h1234);
    chk("n1_mac_w", 32'(mac_w1), 32'(wfn(0)));
    chk("n1_busy_drain", 32'(busy1), 1);
    chk("n1_done_early", 32'(done1), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("n1_done", 32'(done1), 1);
    chk("n1_busy_done", 32'(busy1), 0);
    chk("n1_mac_valid_after", 32'(mac_valid1), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("n1_done_pulse", 32'(done1), 0);
    chk("n1_err", 32'(err1), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
